// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the instruction memory hold/clear
// controls and tracks the valid fetch that sits at the memory output.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic [31:0] imem_addr,
   output logic        imem_hold,
   output logic        imem_clr,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        fault,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {StBoot, StRun, StHalt, StFault} state_e;

   // 33 bits so a 4 GiB memory bound still compares correctly.
   localparam logic [32:0] ImemBytes = 33'(IMEM_WORDS) << 2;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic        if_valid_q, if_valid_d;
   logic        fault_q, fault_d;
   logic [31:0] cnt_q, cnt_d;
   logic        redirect_ok;
   logic        last_word;

   assign redirect_ok = (redirect_pc[1:0] == 2'b00) && ({1'b0, redirect_pc} < ImemBytes);
   assign last_word   = ({1'b0, pc_q} + 33'd4) >= ImemBytes;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_valid_d = if_valid_q;
      fault_d    = fault_q;
      cnt_d      = cnt_q;
      imem_hold  = 1'b0;
      imem_clr   = 1'b0;
      unique case (state_q)
         StBoot: begin
            imem_clr   = 1'b1;
            if_valid_d = 1'b0;
            state_d    = StRun;
         end
         StRun: begin
            if (redirect) begin
               imem_clr   = 1'b1;
               if_valid_d = 1'b0;
               if (redirect_ok) begin
                  pc_d = redirect_pc;
               end else begin
                  state_d = StFault;
                  fault_d = 1'b1;
               end
            end else if (halt) begin
               imem_clr   = 1'b1;
               if_valid_d = 1'b0;
               state_d    = StHalt;
            end else if (stall) begin
               imem_hold = 1'b1;
            end else begin
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
               // The last word is still fetched; the PC then parks instead of wrapping.
               if (last_word) begin
                  state_d = StFault;
                  fault_d = 1'b1;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
         end
         StHalt: begin
            imem_clr   = 1'b1;
            if_valid_d = 1'b0;
            if (redirect) begin
               if (redirect_ok) begin
                  pc_d = redirect_pc;
               end else begin
                  state_d = StFault;
                  fault_d = 1'b1;
               end
            end else if (!halt) begin
               state_d = StRun;
            end
         end
         default: begin
            imem_clr   = 1'b1;
            if_valid_d = 1'b0;
            fault_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StBoot;
         pc_q       <= RESET_PC;
         if_pc_q    <= 32'h0;
         if_valid_q <= 1'b0;
         fault_q    <= 1'b0;
         cnt_q      <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_valid_q <= if_valid_d;
         fault_q    <= fault_d;
         cnt_q      <= cnt_d;
      end
   end

   assign imem_addr = pc_q;
   assign if_pc     = if_pc_q;
   assign if_valid  = if_valid_q;
   assign fault     = fault_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: default-size instance plus an 8-word instance for the
// end-of-memory case, both driven from the same inputs.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, redirect = 1'b0, halt = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   logic [31:0] addr, if_pc, cnt;
   logic        hold, clr, valid, fault;
   logic [31:0] s_addr, s_if_pc, s_cnt;
   logic        s_hold, s_clr, s_valid, s_fault;

   int n_cmp = 0;
   int n_err = 0;

   fetch_ctrl u_dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt(halt), .imem_addr(addr), .imem_hold(hold), .imem_clr(clr), .if_pc(if_pc),
      .if_valid(valid), .fault(fault), .fetch_cnt(cnt)
   );

   fetch_ctrl #(.IMEM_WORDS(8)) u_small (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt(halt), .imem_addr(s_addr), .imem_hold(s_hold), .imem_clr(s_clr), .if_pc(s_if_pc),
      .if_valid(s_valid), .fault(s_fault), .fetch_cnt(s_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall       = 1'b0;
      redirect    = 1'b0;
      halt        = 1'b0;
      redirect_pc = 32'h0;
   endtask

   // Assert reset between edges, then release it just after an edge (state BOOT).
   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      #2;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset values
      #2;
      chk("rst_addr", addr, 32'h0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      chk("rst_cnt", cnt, 32'd0);
      chk("rst_clr", {31'b0, clr}, 32'd1);
      chk("rst_hold", {31'b0, hold}, 32'd0);
      tick();
      rst = 1'b0;

      // Boot and sequential fetch
      chk("boot_addr0", addr, 32'h0);
      tick();
      chk("boot_addr1", addr, 32'h0);
      chk("boot_valid1", {31'b0, valid}, 32'd0);
      chk("run_clr", {31'b0, clr}, 32'd0);
      tick();
      chk("seq_addr2", addr, 32'h4);
      chk("seq_valid2", {31'b0, valid}, 32'd1);
      chk("seq_if_pc2", if_pc, 32'h0);
      tick();
      chk("seq_addr3", addr, 32'h8);
      chk("seq_if_pc3", if_pc, 32'h4);
      tick();
      chk("seq_addr4", addr, 32'hC);
      chk("seq_if_pc4", if_pc, 32'h8);
      chk("seq_cnt4", cnt, 32'd3);

      // Stall for three cycles at 0x10
      tick();
      chk("pre_stall_addr", addr, 32'h10);
      stall = 1'b1;
      #1;
      chk("stall_hold", {31'b0, hold}, 32'd1);
      chk("stall_clr", {31'b0, clr}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_addr", addr, 32'h10);
         chk("stall_if_pc", if_pc, 32'hC);
         chk("stall_cnt", cnt, 32'd4);
      end
      stall = 1'b0;
      tick();
      chk("unstall_addr", addr, 32'h14);
      chk("unstall_if_pc", if_pc, 32'h10);
      chk("unstall_cnt", cnt, 32'd5);

      // Redirect beats a simultaneous stall
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      #1;
      chk("redir_clr", {31'b0, clr}, 32'd1);
      chk("redir_hold", {31'b0, hold}, 32'd0);
      tick();
      clear_inputs();
      chk("redir_addr", addr, 32'h40);
      chk("redir_valid", {31'b0, valid}, 32'd0);
      tick();
      chk("redir_if_pc", if_pc, 32'h40);
      chk("redir_valid2", {31'b0, valid}, 32'd1);
      chk("redir_cnt", cnt, 32'd6);

      // Halt at 0x20, redirect to 0x80 while halted, then resume
      redirect    = 1'b1;
      redirect_pc = 32'h20;
      tick();
      redirect = 1'b0;
      halt     = 1'b1;
      #1;
      chk("halt_clr_run", {31'b0, clr}, 32'd1);
      tick();
      chk("halt_addr", addr, 32'h20);
      chk("halt_valid", {31'b0, valid}, 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      tick();
      redirect = 1'b0;
      chk("halt_redir_addr", addr, 32'h80);
      chk("halt_redir_valid", {31'b0, valid}, 32'd0);
      tick();
      chk("halt_hold_addr", addr, 32'h80);
      halt = 1'b0;
      #1;
      chk("halt_clr", {31'b0, clr}, 32'd1);
      tick();
      chk("resume_valid0", {31'b0, valid}, 32'd0);
      chk("resume_addr0", addr, 32'h80);
      tick();
      chk("resume_if_pc", if_pc, 32'h80);
      chk("resume_valid", {31'b0, valid}, 32'd1);
      chk("resume_cnt", cnt, 32'd7);

      // Misaligned redirect faults; fault is sticky until reset
      redirect    = 1'b1;
      redirect_pc = 32'h42;
      tick();
      chk("mis_fault", {31'b0, fault}, 32'd1);
      chk("mis_addr", addr, 32'h84);
      chk("mis_valid", {31'b0, valid}, 32'd0);
      redirect_pc = 32'h0;
      stall       = 1'b1;
      #1;
      chk("fault_clr", {31'b0, clr}, 32'd1);
      chk("fault_hold", {31'b0, hold}, 32'd0);
      tick();
      chk("fault_sticky", {31'b0, fault}, 32'd1);
      chk("fault_addr", addr, 32'h84);
      chk("fault_cnt", cnt, 32'd7);
      rst = 1'b1;
      #2;
      chk("arst_fault", {31'b0, fault}, 32'd0);
      chk("arst_addr", addr, 32'h0);
      chk("arst_cnt", cnt, 32'd0);
      chk("arst_clr", {31'b0, clr}, 32'd1);
      do_reset();

      // Last legal word of the default memory, then the out-of-range target
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h3FFC;
      tick();
      redirect = 1'b0;
      chk("top_addr", addr, 32'h3FFC);
      chk("top_fault0", {31'b0, fault}, 32'd0);
      tick();
      chk("top_if_pc", if_pc, 32'h3FFC);
      chk("top_valid", {31'b0, valid}, 32'd1);
      chk("top_fault", {31'b0, fault}, 32'd1);
      chk("top_addr_held", addr, 32'h3FFC);
      tick();
      chk("top_valid_after", {31'b0, valid}, 32'd0);
      do_reset();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h4000;
      tick();
      redirect = 1'b0;
      chk("oor_fault", {31'b0, fault}, 32'd1);
      chk("oor_addr", addr, 32'h0);

      // 8-word memory runs off its end
      do_reset();
      tick();
      repeat (7) tick();
      chk("eom_pre_addr", s_addr, 32'h1C);
      chk("eom_pre_fault", {31'b0, s_fault}, 32'd0);
      tick();
      chk("eom_if_pc", s_if_pc, 32'h1C);
      chk("eom_valid", {31'b0, s_valid}, 32'd1);
      chk("eom_fault", {31'b0, s_fault}, 32'd1);
      chk("eom_addr", s_addr, 32'h1C);
      chk("eom_cnt", s_cnt, 32'd8);
      tick();
      chk("eom_valid_after", {31'b0, s_valid}, 32'd0);
      chk("eom_addr_after", s_addr, 32'h1C);
      chk("eom_cnt_after", s_cnt, 32'd8);

      // Reset asserted during a stall
      do_reset();
      tick();
      tick();
      stall = 1'b1;
      tick();
      chk("rs_hold", {31'b0, hold}, 32'd1);
      chk("rs_addr", addr, 32'h4);
      rst = 1'b1;
      #2;
      chk("rs_hold_rst", {31'b0, hold}, 32'd0);
      chk("rs_clr_rst", {31'b0, clr}, 32'd1);
      chk("rs_addr_rst", addr, 32'h0);
      chk("rs_valid_rst", {31'b0, valid}, 32'd0);
      chk("rs_cnt_rst", cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
